// File: rtl/om_write_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : om_write_ctrl_pkg
// Description : Shared accelerator definitions for the output-memory write
//               controller: default widths and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package om_write_ctrl_pkg;

    localparam int c_OM_DATA_W = 8;
    localparam int c_OM_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } om_state_t;

endpackage
`default_nettype wire

// File: rtl/om_addr_counter.sv
`default_nettype none
// ============================================================================
// Module      : om_addr_counter
// Description : Clearable/incrementing word counter with terminal-count flag,
//               one bit wider than the address so a full memory never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module om_addr_counter
    import om_write_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_OM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [ADDR_W:0]   i_last,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_at_last
);

    localparam logic [ADDR_W:0] c_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_addr    = r_count[ADDR_W-1:0];
    assign o_at_last = (r_count == i_last);

endmodule
`default_nettype wire

// File: rtl/om_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : om_write_ctrl
// Description : Output-memory write controller. Fills the memory with N
//               datapath results, holds it full, then drains it on demand.
// Revision    : 1.0 - initial release
// ============================================================================
module om_write_ctrl
    import om_write_ctrl_pkg::*;
#(
    parameter int DATA_W = c_OM_DATA_W,
    parameter int ADDR_W = c_OM_ADDR_W
) (
    input  logic              OM_WRITE_CTRL_Clk,
    input  logic              OM_WRITE_CTRL_Reset,
    input  logic              OM_WRITE_CTRL_Start,
    input  logic [ADDR_W:0]   OM_WRITE_CTRL_Num_Outputs,
    input  logic              OM_WRITE_CTRL_Result_Valid,
    input  logic [DATA_W-1:0] OM_WRITE_CTRL_Result_Data,
    input  logic              OM_WRITE_CTRL_Drain_Ready,
    input  logic              OM_WRITE_CTRL_Abort,
    output logic              OM_WRITE_CTRL_Wr_En,
    output logic [ADDR_W-1:0] OM_WRITE_CTRL_Wr_Addr,
    output logic [DATA_W-1:0] OM_WRITE_CTRL_Wr_Data,
    output logic              OM_WRITE_CTRL_Rd_En,
    output logic [ADDR_W-1:0] OM_WRITE_CTRL_Rd_Addr,
    output logic              OM_WRITE_CTRL_Flag_Om_Full,
    output logic              OM_WRITE_CTRL_Datapath_En,
    output logic              OM_WRITE_CTRL_Done,
    output logic              OM_WRITE_CTRL_Overflow,
    output logic              OM_WRITE_CTRL_Busy
);

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    om_state_t         r_state;
    om_state_t         w_state_nxt;

    logic [ADDR_W:0]   r_num_words;
    logic [ADDR_W:0]   w_last_idx;
    logic              w_num_ok;
    logic              w_start_ok;
    logic              w_wr_inc;
    logic              w_rd_inc;
    logic              w_wr_at_last;
    logic              w_rd_at_last;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;

    logic              w_wr_en_nxt;
    logic              w_rd_en_nxt;
    logic              w_done_nxt;
    logic              w_ovf_nxt;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_flag_full;
    logic              r_dp_en;
    logic              r_done;
    logic              r_overflow;
    logic              r_busy;

    assign w_last_idx = r_num_words - c_ONE;
    assign w_num_ok   = (OM_WRITE_CTRL_Num_Outputs != '0) &&
                        (OM_WRITE_CTRL_Num_Outputs <= c_DEPTH);

    om_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_wr_cnt (
        .clk       (OM_WRITE_CTRL_Clk),
        .rst       (OM_WRITE_CTRL_Reset),
        .i_clr     (w_start_ok),
        .i_inc     (w_wr_inc),
        .i_last    (w_last_idx),
        .o_addr    (w_wr_addr),
        .o_at_last (w_wr_at_last)
    );

    om_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_rd_cnt (
        .clk       (OM_WRITE_CTRL_Clk),
        .rst       (OM_WRITE_CTRL_Reset),
        .i_clr     (w_start_ok),
        .i_inc     (w_rd_inc),
        .i_last    (w_last_idx),
        .o_addr    (w_rd_addr),
        .o_at_last (w_rd_at_last)
    );

    always_ff @(posedge OM_WRITE_CTRL_Clk) begin
        if (OM_WRITE_CTRL_Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_wr_inc    = 1'b0;
        w_rd_inc    = 1'b0;
        w_wr_en_nxt = 1'b0;
        w_rd_en_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_ovf_nxt   = r_overflow;

        if (OM_WRITE_CTRL_Abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            // Any result arriving while not filling is lost and must be flagged.
            if (OM_WRITE_CTRL_Result_Valid && (r_state != ST_FILL)) begin
                w_ovf_nxt = 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (OM_WRITE_CTRL_Start && w_num_ok) begin
                        w_state_nxt = ST_FILL;
                        w_start_ok  = 1'b1;
                        w_ovf_nxt   = OM_WRITE_CTRL_Result_Valid;
                    end
                end
                ST_FILL: begin
                    if (OM_WRITE_CTRL_Result_Valid) begin
                        w_wr_en_nxt = 1'b1;
                        w_wr_inc    = 1'b1;
                        if (w_wr_at_last) begin
                            w_state_nxt = ST_FULL;
                        end
                    end
                end
                ST_FULL, ST_DRAIN: begin
                    // The first ready seen while FULL already issues read 0.
                    if (OM_WRITE_CTRL_Drain_Ready) begin
                        w_rd_en_nxt = 1'b1;
                        w_rd_inc    = 1'b1;
                        if (w_rd_at_last) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge OM_WRITE_CTRL_Clk) begin
        if (OM_WRITE_CTRL_Reset) begin
            r_num_words <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_flag_full <= 1'b0;
            r_dp_en     <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_num_words <= OM_WRITE_CTRL_Num_Outputs;
            end
            r_wr_en <= w_wr_en_nxt;
            if (w_wr_en_nxt) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= OM_WRITE_CTRL_Result_Data;
            end
            r_rd_en <= w_rd_en_nxt;
            if (w_rd_en_nxt) begin
                r_rd_addr <= w_rd_addr;
            end
            r_flag_full <= (w_state_nxt == ST_FULL) || (w_state_nxt == ST_DRAIN);
            r_dp_en     <= (w_state_nxt == ST_FILL);
            r_done      <= w_done_nxt;
            r_overflow  <= w_ovf_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign OM_WRITE_CTRL_Wr_En         = r_wr_en;
    assign OM_WRITE_CTRL_Wr_Addr       = r_wr_addr;
    assign OM_WRITE_CTRL_Wr_Data       = r_wr_data;
    assign OM_WRITE_CTRL_Rd_En         = r_rd_en;
    assign OM_WRITE_CTRL_Rd_Addr       = r_rd_addr;
    assign OM_WRITE_CTRL_Flag_Om_Full  = r_flag_full;
    assign OM_WRITE_CTRL_Datapath_En   = r_dp_en;
    assign OM_WRITE_CTRL_Done          = r_done;
    assign OM_WRITE_CTRL_Overflow      = r_overflow;
    assign OM_WRITE_CTRL_Busy          = r_busy;

endmodule
`default_nettype wire

// File: doc/om_write_ctrl.md
OM_WRITE_CTRL -- requirements
Module: om_write_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of one convolution result word.
REQ-002 Parameter ADDR_W, default 10: output-memory address width; DEPTH = 2**ADDR_W.
REQ-003 OM_WRITE_CTRL_Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 OM_WRITE_CTRL_Reset  in  1  synchronous, active-high reset.
REQ-005 OM_WRITE_CTRL_Start  in  1  one-cycle pulse that begins a fill of the output memory.
REQ-006 OM_WRITE_CTRL_Num_Outputs  in  ADDR_W+1  number of words per feature map, sampled on an accepted Start.
REQ-007 OM_WRITE_CTRL_Result_Valid  in  1  datapath result is valid this cycle.
REQ-008 OM_WRITE_CTRL_Result_Data  in  DATA_W  datapath result word.
REQ-009 OM_WRITE_CTRL_Drain_Ready  in  1  consumer accepts one read this cycle.
REQ-010 OM_WRITE_CTRL_Abort  in  1  forces an immediate return to IDLE.
REQ-011 OM_WRITE_CTRL_Wr_En / _Wr_Addr / _Wr_Data  out  1/ADDR_W/DATA_W  output-memory write port.
REQ-012 OM_WRITE_CTRL_Rd_En / _Rd_Addr  out  1/ADDR_W  output-memory read port.
REQ-013 OM_WRITE_CTRL_Flag_Om_Full  out  1  memory holds a complete map; drives the set-enable clear logic.
REQ-014 OM_WRITE_CTRL_Datapath_En  out  1  datapath may produce results.
REQ-015 OM_WRITE_CTRL_Done  out  1  one-cycle pulse at drain completion.
REQ-016 OM_WRITE_CTRL_Overflow  out  1  sticky: a result arrived outside FILL.
REQ-017 OM_WRITE_CTRL_Busy  out  1  state is not IDLE.

Function
REQ-018 FSM states: IDLE, FILL, FULL, DRAIN; the state register and all outputs are registered.
REQ-019 IDLE: Start with 1 <= Num_Outputs <= DEPTH -> FILL; wr count cleared, Num_Outputs latched, Overflow cleared.
REQ-020 IDLE: Start with Num_Outputs = 0 or > DEPTH is ignored; the FSM stays in IDLE.
REQ-021 Start outside IDLE is ignored.
REQ-022 FILL: Datapath_En = 1; each Result_Valid produces Wr_En = 1 one cycle later, with Wr_Addr = the current count and Wr_Data = the captured word; the count then increments.
REQ-023 FILL: the Result_Valid that writes word N-1 moves the FSM to FULL; Flag_Om_Full = 1 and Datapath_En = 0 in the following cycle.
REQ-024 FULL: Flag_Om_Full is held at 1; the first cycle with Drain_Ready = 1 moves the FSM to DRAIN with the read count at 0.
REQ-025 DRAIN: each cycle with Drain_Ready = 1 gives Rd_En = 1 and Rd_Addr = the read count, and the count increments; Rd_En = 0 when Drain_Ready = 0.
REQ-026 DRAIN: Flag_Om_Full stays at 1 until the read of word N-1 is issued, and falls in the same cycle that Done pulses.
REQ-027 DRAIN: the read of word N-1 moves the FSM to IDLE and produces a Done pulse of exactly one cycle.
REQ-028 A Result_Valid in IDLE, FULL or DRAIN is not written and sets Overflow; Overflow holds until the next accepted Start or reset.
REQ-029 Abort has priority over every other input: the FSM goes to IDLE the next cycle, all enables and flags go to 0, and Overflow is kept.
REQ-030 Counters are ADDR_W+1 bits so that DEPTH words can be counted without wrap; addresses use the low ADDR_W bits.
REQ-031 Simultaneous Start and Abort in IDLE: Abort wins and Start is dropped.

Reset
REQ-032 Reset drives state = IDLE, both counters = 0, and Wr_En, Rd_En, Flag_Om_Full, Datapath_En, Done, Overflow and Busy = 0.
REQ-033 Reset mid-operation discards the fill/drain in progress; no write or read is issued in the cycle after reset.

Structure
REQ-034 The FSM state encoding and the DATA_W/ADDR_W defaults are defined in the shared accelerator package.
REQ-035 Flag_Om_Full connects directly to the existing set-enable clear block; no sub-module is instantiated beyond an optional om_addr_counter (load/increment/terminal-count), reused for both the write and read counts.

Verification
REQ-036 Reset, then Start with N = 4 and 4 consecutive valids (data 0x11..0x44) -> Wr_En on addresses 0..3 with matching data; Flag_Om_Full = 1 the cycle after the last write.
REQ-037 FULL, then Drain_Ready pattern 1,0,1,1,1 -> Rd_Addr 0,-,1,2,3; Done pulses with the read of address 3; Flag_Om_Full = 0 in the same cycle; FSM returns to IDLE.
REQ-038 N = DEPTH = 1024 -> addresses 0..1023 written with no wrap; FULL entered after write 1023.
REQ-039 Result_Valid asserted in FULL -> no Wr_En, Overflow = 1; Overflow stays 1 until the next Start.
REQ-040 Abort after 2 of 4 writes -> IDLE next cycle with all outputs 0; a following Start with N = 0 -> FSM stays in IDLE.
